rs232_send_arbiter: RTL and testbench
=====================================

// Module: rs232_send_arbiter
// PURPOSE
//  Shares one rs232_send byte channel between PORTS independent byte-stream requesters.
//  Arbitration is round-robin at packet granularity.
//  A granted requester keeps the channel until it transfers a byte flagged last, so messages never interleave.
//  Sits between the debug/status producers and rs232_send: out_* drives rs232_send data/valid, and out_ready is its ready.
// PARAMETERS
//  PORTS    4     number of requesters, 2..8
//  TIMEOUT  1024  idle cycles of the owner mid-packet before forced release; 0 disables the timeout
// PORTS
//  clock          in   1          system clock
//  reset_n        in   1          asynchronous, active-low reset
//  in_data        in   PORTS*8    byte of requester i at [8*i+7:8*i]
//  in_valid       in   PORTS      requester i has a byte
//  in_last        in   PORTS      byte of requester i ends its packet
//  in_ready       out  PORTS      byte of requester i accepted this cycle (valid&&ready)
//  out_data       out  8          byte to rs232_send (registered)
//  out_valid      out  1          out_data valid (registered)
//  out_ready      in   1          rs232_send ready
//  owner          out  OW         current/last owner index; OW = max(1,$clog2(PORTS))
//  busy           out  1          1 while in LOCKED
//  timeout_pulse  out  1          one-cycle pulse on forced release
// BEHAVIOUR
//  Reset values (asynchronous): state=IDLE, out_valid=0, out_data=0, owner=0, rr_ptr=0, busy=0,
//   timeout_pulse=0, idle counter=0. in_ready is combinational and therefore 0 during reset.
//  Output register:
//   - may load when out_free = !out_valid || out_ready;
//   - once out_valid=1, out_data is held stable until out_ready.
//   - in_ready[i] = (state==LOCKED) && (owner==i) && out_free; all other in_ready bits are 0.
//   - Beat i accepted: out_data<=in_data[i], out_valid<=1.
//   - Accept with no new beat: out_valid<=0 when out_ready && out_valid.
//  IDLE:
//   - If any in_valid, pick the first set bit searching rr_ptr, rr_ptr+1, ... modulo PORTS.
//   - owner<=pick, state<=LOCKED, so arbitration latency is 1 cycle.
//   - No bytes are transferred in IDLE.
//  LOCKED:
//   - Transfers owner bytes.
//   - Accepted beat with in_last[owner]: state<=IDLE, rr_ptr<=owner+1 mod PORTS (wraps PORTS-1 -> 0).
//   - Last byte may still sit in the output register after the return to IDLE; it drains normally.
//  Timeout:
//   - In LOCKED, the counter increments on each cycle with in_valid[owner]=0 and clears on any cycle with in_valid[owner]=1.
//   - When the counter reaches TIMEOUT-1 with valid still low: state<=IDLE, rr_ptr<=owner+1, timeout_pulse=1 next cycle.
//   - The counter clears on entry to LOCKED.
//  Throughput: one byte per cycle when out_ready is held 1. rs232_send itself is far slower.
//  Simultaneous events:
//   - Last beat and timeout expiry in the same cycle: treat as a normal last beat (no pulse).
//   - Requests in IDLE while the output register is still full: grant proceeds; the byte waits on out_free.
//  Owner deasserts valid mid-packet: the lock is held (no interleave) until last or timeout.
//  Reset mid-operation: all state is dropped, including a byte pending in the output register.
//   The owning requester must restart its packet.
//  Width rules:
//   - Counter width = $clog2(TIMEOUT+1), saturating.
//   - rr_ptr and owner are OW bits; index arithmetic wraps explicitly at PORTS (not at 2^OW).
// STRUCTURE
//  Shared constants file: RS232_BYTE_W=8 and the default CLOCK_FREQ/BAUD_RATE, also used by rs232_send.
//  No typedefs are required.
//  Sub-module rs232_rr_pick: combinational round-robin picker.
//   - Inputs: req[PORTS], ptr[OW].
//   - Outputs: any, idx[OW].
//   - Implementation: double-width masked priority encode.
//  The FSM, output register and timeout counter stay in this module.
// TESTING (PORTS=4, TIMEOUT=16, out_ready model mimics rs232_send: ready for 1 cycle every 20)
//  1. Only req 2 sends "AB" (last on 'B') -> out sequence 0x41,0x42; owner=2; afterwards busy=0 and rr_ptr=3.
//  2. Reqs 0,1,3 each hold valid with 3-byte packets -> packet order 0,1,3,0; bytes never interleave.
//  3. Req 1 sends 1 byte with last=0, then drops valid for 16 cycles -> timeout_pulse=1 once; req 3 is granted next.
//  4. out_ready held 0 for 50 cycles with out_valid=1 -> out_data stable; in_ready all 0; no byte lost or duplicated.
//  5. Assert reset_n=0 mid-packet with out_valid=1 -> out_valid=0 immediately; in IDLE after release; rr_ptr=0.
//  6. Scoreboard random traffic for 10k cycles -> each requester's byte stream is reproduced in order and packets are atomic.

Source files
------------

// File: rtl/rs232_send_arbiter_pkg.sv
// Constants shared by the rs232 send path (byte width and default line timing).
package rs232_send_arbiter_pkg;
    localparam int RS232_BYTE_W = 8;
    localparam int CLOCK_FREQ   = 50_000_000;
    localparam int BAUD_RATE    = 115_200;

    // Index width for a port count; never narrower than one bit.
    function automatic int ow_of(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction
endpackage

// File: rtl/rs232_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at PORTS.
module rs232_rr_pick #(
    parameter int PORTS = 4,
    parameter int OW    = 2
) (
    input  logic [PORTS-1:0] req,
    input  logic [OW-1:0]    ptr,
    output logic             any,
    output logic [OW-1:0]    idx
);
    logic [2*PORTS-1:0] dbl;
    logic               found;

    // Low half holds requests at/after ptr, high half the full set as the wrapped fallback.
    always_comb begin
        dbl = '0;
        for (int i = 0; i < PORTS; i++) begin
            dbl[i]         = req[i] && (i >= int'(ptr));
            dbl[PORTS + i] = req[i];
        end
        any   = |req;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < 2*PORTS; i++) begin
            if (!found && dbl[i]) begin
                found = 1'b1;
                idx   = (i >= PORTS) ? OW'(i - PORTS) : OW'(i);
            end
        end
    end
endmodule

// File: rtl/rs232_send_arbiter.sv
// Packet-atomic round-robin arbiter sharing one rs232_send byte channel among PORTS requesters.
module rs232_send_arbiter
    import rs232_send_arbiter_pkg::*;
#(
    parameter int  PORTS   = 4,
    parameter int  TIMEOUT = 1024,
    localparam int OW      = ow_of(PORTS)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [PORTS*8-1:0]        in_data,
    input  logic [PORTS-1:0]          in_valid,
    input  logic [PORTS-1:0]          in_last,
    output logic [PORTS-1:0]          in_ready,
    output logic [RS232_BYTE_W-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OW-1:0]             owner,
    output logic                      busy,
    output logic                      timeout_pulse
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                                 state;
    logic [OW-1:0]                          rr_ptr;
    logic [CW-1:0]                          idle_cnt;
    logic [PORTS-1:0][RS232_BYTE_W-1:0]     in_bytes;
    logic                                   out_free;
    logic                                   owner_valid;
    logic                                   owner_last;
    logic                                   accept;
    logic                                   expire;
    logic                                   pick_any;
    logic [OW-1:0]                          pick_idx;
    logic [OW-1:0]                          next_ptr;

    assign in_bytes    = in_data;
    assign out_free    = !out_valid || out_ready;
    assign owner_valid = in_valid[owner];
    assign owner_last  = in_last[owner];
    assign accept      = (state == LOCKED) && owner_valid && out_free;
    assign next_ptr    = (owner == OW'(PORTS - 1)) ? '0 : owner + 1'b1;
    assign expire      = (TIMEOUT != 0) && (idle_cnt == CW'(TIMEOUT - 1)) && !owner_valid;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < PORTS; i++)
            in_ready[i] = (state == LOCKED) && (owner == OW'(i)) && out_free;
    end

    rs232_rr_pick #(.PORTS(PORTS), .OW(OW)) u_pick (
        .req (in_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            out_valid     <= 1'b0;
            out_data      <= '0;
            owner         <= '0;
            rr_ptr        <= '0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
            idle_cnt      <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            if (accept) begin
                out_data  <= in_bytes[owner];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner    <= pick_idx;
                        state    <= LOCKED;
                        busy     <= 1'b1;
                        idle_cnt <= '0;
                    end
                end
                LOCKED: begin
                    // A last beat wins over expiry; the two cannot both carry valid anyway.
                    if (accept && owner_last) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end else if (expire) begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        rr_ptr        <= next_ptr;
                        timeout_pulse <= 1'b1;
                    end else if (owner_valid) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rs232_send_arbiter.sv
// Randomized scoreboard bench for rs232_send_arbiter with directed scenarios up front.
module tb_rs232_send_arbiter;
    localparam int P  = 4;
    localparam int TO = 16;
    localparam int OW = 2;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [P*8-1:0] in_data;
    logic [P-1:0]   in_valid, in_last, in_ready;
    logic [7:0]     out_data;
    logic           out_valid, out_ready;
    logic [OW-1:0]  owner;
    logic           busy, timeout_pulse;

    always #5 clock = ~clock;

    rs232_send_arbiter #(.PORTS(P), .TIMEOUT(TO)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .owner         (owner),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    int n_chk = 0, n_err = 0;

    // Per-requester pending bytes {last, byte}, circular.
    logic [8:0] gbuf [P][64];
    int         head [P];
    int         tail [P];
    logic [7:0] exp_q[$];
    int         pkt_log[$];
    logic [7:0] out_log[$];
    bit         mid;
    int         mid_port, low_run, exp_ptr, pulse_cnt, out_total;
    bit         prev_hold;
    logic [7:0] prev_od;
    bit         hold_low, gap_on, gen_on, rnd_rdy;
    int         rdy_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int qlen(input int p);
        return tail[p] - head[p];
    endfunction

    task automatic push(input int p, input logic [7:0] b, input logic l);
        gbuf[p][tail[p] % 64] = {l, b};
        tail[p]++;
    endtask

    task automatic push_pkt(input int p, input int len);
        for (int k = 0; k < len; k++) push(p, 8'($urandom), k == len - 1);
    endtask

    function automatic bit all_empty();
        for (int p = 0; p < P; p++) if (qlen(p) != 0) return 0;
        return 1;
    endfunction

    task automatic clear_model();
        for (int p = 0; p < P; p++) begin head[p] = 0; tail[p] = 0; end
        exp_q.delete();
        out_log.delete();
        pkt_log.delete();
        mid = 0; low_run = 0; exp_ptr = 0; prev_hold = 0; pulse_cnt = 0;
    endtask

    // Reference rules applied to what was seen just before the coming edge.
    task automatic observe();
        int acc_p;
        if (timeout_pulse) begin
            pulse_cnt++;
            if (mid) begin
                chk("timeout_delay", low_run, TO);
                exp_ptr = (mid_port + 1) % P;
                mid = 0;
            end else begin
                exp_ptr = (int'(owner) + 1) % P;
            end
        end else if (mid && low_run >= TO) begin
            chk("timeout_missing", timeout_pulse, 1);
            mid = 0;
        end
        chk("rr_ptr", dut.rr_ptr, exp_ptr);
        chk("in_ready_legal", $onehot0(in_ready) && (busy || in_ready == '0) &&
            !(out_valid && !out_ready && in_ready != '0), 1);
        if (prev_hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_od);
        end
        if (out_valid && out_ready) begin
            out_log.push_back(out_data);
            out_total++;
            if (exp_q.size() == 0) chk("out_extra", 1, 0);
            else chk("out_byte", out_data, exp_q.pop_front());
        end
        acc_p = -1;
        for (int p = 0; p < P; p++) if (in_ready[p] && in_valid[p]) acc_p = p;
        if (acc_p >= 0) begin
            if (mid) chk("atomic_port", acc_p, mid_port);
            else pkt_log.push_back(acc_p);
            exp_q.push_back(in_data[8*acc_p +: 8]);
            head[acc_p]++;
            if (in_last[acc_p]) begin
                mid = 0;
                exp_ptr = (acc_p + 1) % P;
            end else begin
                mid = 1; mid_port = acc_p; low_run = 0;
            end
        end else if (mid) begin
            if (in_valid[mid_port]) low_run = 0;
            else low_run++;
        end
        prev_hold = out_valid && !out_ready;
        prev_od   = out_data;
    endtask

    task automatic tick();
        @(negedge clock);
        for (int p = 0; p < P; p++)
            if (gen_on && qlen(p) == 0 && $urandom_range(0, 29) == 0)
                push_pkt(p, $urandom_range(1, 5));
        in_valid = '0;
        in_last  = '0;
        in_data  = $urandom;
        for (int p = 0; p < P; p++)
            if (qlen(p) > 0 && !(gap_on && $urandom_range(0, 7) == 0)) begin
                in_valid[p] = 1'b1;
                {in_last[p], in_data[8*p +: 8]} = gbuf[p][head[p] % 64];
            end
        if (hold_low) out_ready = 1'b0;
        else if (rnd_rdy) out_ready = ($urandom_range(0, 2) == 0);
        else begin
            rdy_cnt   = (rdy_cnt + 1) % 20;
            out_ready = (rdy_cnt == 0);
        end
        #1;
        observe();
    endtask

    task automatic wait_drain(input int max);
        int k = 0;
        while ((!all_empty() || exp_q.size() != 0 || out_valid) && k < max) begin
            tick();
            k++;
        end
        chk("drain_in_time", k < max, 1);
    endtask

    // Asynchronous reset taken between edges, then released after two edges.
    task automatic do_reset();
        #1 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        clear_model();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int k;
        reset_n = 1'b0; in_valid = '1; in_last = '1; in_data = 32'h5a5a_5a5a; out_ready = 1'b1;
        hold_low = 0; gap_on = 0; gen_on = 0; rnd_rdy = 0; out_total = 0;
        #12;
        chk("rst0_out_valid", out_valid, 0);
        chk("rst0_out_data", out_data, 0);
        chk("rst0_owner", owner, 0);
        chk("rst0_busy", busy, 0);
        chk("rst0_pulse", timeout_pulse, 0);
        chk("rst0_in_ready", in_ready, 0);
        chk("rst0_idle_cnt", dut.idle_cnt, 0);
        clear_model();
        tick(); tick();
        reset_n = 1'b1;

        // 1: lone requester 2 sends "AB"
        push(2, 8'h41, 0); push(2, 8'h42, 1);
        wait_drain(200);
        chk("t1_count", out_log.size(), 2);
        chk("t1_byte0", out_log[0], 8'h41);
        chk("t1_byte1", out_log[1], 8'h42);
        chk("t1_owner", owner, 2);
        chk("t1_busy", busy, 0);
        chk("t1_rr_ptr", dut.rr_ptr, 3);

        // 2: three contenders, port 0 with two packets
        do_reset();
        push_pkt(0, 3); push_pkt(0, 3); push_pkt(1, 3); push_pkt(3, 3);
        wait_drain(600);
        chk("t2_pkts", pkt_log.size(), 4);
        chk("t2_order0", pkt_log[0], 0);
        chk("t2_order1", pkt_log[1], 1);
        chk("t2_order2", pkt_log[2], 3);
        chk("t2_order3", pkt_log[3], 0);
        chk("t2_bytes", out_log.size(), 12);

        // 3: owner 1 stalls mid-packet until forced release, then 3 takes over
        do_reset();
        push(1, 8'h11, 0);
        k = 0;
        while (qlen(1) != 0 && k < 100) begin tick(); k++; end
        chk("t3_first_beat", k < 100, 1);
        push_pkt(3, 2);
        k = 0;
        while (pulse_cnt == 0 && k < 100) begin tick(); k++; end
        chk("t3_pulse_seen", k < 100, 1);
        wait_drain(300);
        chk("t3_pulses", pulse_cnt, 1);
        chk("t3_pkts", pkt_log.size(), 2);
        chk("t3_order0", pkt_log[0], 1);
        chk("t3_order1", pkt_log[1], 3);

        // 4: downstream stalled with a byte pending
        do_reset();
        push_pkt(0, 4);
        k = 0;
        while (!out_valid && k < 100) begin tick(); k++; end
        chk("t4_loaded", k < 100, 1);
        hold_low = 1;
        repeat (50) tick();
        chk("t4_held", out_valid, 1);
        hold_low = 0;
        wait_drain(300);
        chk("t4_bytes", out_log.size(), 4);

        // 5: reset mid-packet with the output register full
        do_reset();
        push_pkt(2, 5);
        k = 0;
        while (!(out_valid && mid) && k < 200) begin tick(); k++; end
        chk("t5_mid", k < 200, 1);
        do_reset();
        repeat (3) tick();
        chk("t5_busy", busy, 0);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_rr_ptr", dut.rr_ptr, 0);

        // 6: random traffic, gappy requesters, varied ready
        do_reset();
        out_total = 0;
        gen_on = 1; gap_on = 1;
        for (int c = 0; c < 10000; c++) begin
            rnd_rdy = (c >= 2000);
            tick();
        end
        gen_on = 0; gap_on = 0;
        wait_drain(5000);
        chk("t6_scoreboard_empty", exp_q.size(), 0);
        chk("t6_traffic", out_total > 200, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
